// File: rtl/vector_result_buf.sv
// Registers gate-stage results into a DEPTH-entry FIFO: push-to-valid is 1 cycle, no bypass, and in_ready = !full.
// Optional consistency check and hit counter are enabled by VECTOR_RESULT_BUF_STATS_EN.
module vector_result_buf #(
   parameter int N     = 3,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_or_bitwise,
   input  logic             in_or_logical,
   input  logic [2*N-1:0]   in_not,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3*N:0]     out_data,
   input  logic             clr,
   output logic             err_sticky,
   output logic [CNT_W-1:0] hit_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int WW = 3 * N + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [WW-1:0] last_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && !full;
   assign pop       = out_ready && !empty;

   // When empty, show the last word that left the FIFO rather than a stale slot.
   assign out_data = empty ? last_q : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            last_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_not, in_or_logical, in_or_bitwise};
      end
   end

`ifdef VECTOR_RESULT_BUF_STATS_EN
   logic [CNT_W-1:0] hit_q;
   logic             err_q;

   // clr wins over any increment or error flagged in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_q <= '0;
         err_q <= 1'b0;
      end else if (clr) begin
         hit_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (push && in_or_logical && (hit_q != {CNT_W{1'b1}})) begin
            hit_q <= hit_q + CNT_W'(1);
         end
         if (push && (in_or_logical != (|in_or_bitwise))) begin
            err_q <= 1'b1;
         end
      end
   end

   assign hit_cnt    = hit_q;
   assign err_sticky = err_q;
`else
   logic unused_clr;
   assign unused_clr = clr;
   assign hit_cnt    = '0;
   assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_vector_result_buf.sv
// Directed bench for vector_result_buf; stats expectations follow VECTOR_RESULT_BUF_STATS_EN.
module tb_vector_result_buf;
   localparam int N     = 3;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;
`ifdef VECTOR_RESULT_BUF_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_or_bitwise;
   logic             in_or_logical;
   logic [2*N-1:0]   in_not;
   logic             out_valid;
   logic             out_ready;
   logic [3*N:0]     out_data;
   logic             clr;
   logic             err_sticky;
   logic [CNT_W-1:0] hit_cnt;

   int checks  = 0;
   int errors  = 0;
   int exp_hit = 0;

   vector_result_buf #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_or_bitwise(in_or_bitwise),
      .in_or_logical(in_or_logical),
      .in_not       (in_not),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .clr          (clr),
      .err_sticky   (err_sticky),
      .hit_cnt      (hit_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [3*N:0] word(input logic [2*N-1:0] nt, input logic lg, input logic [N-1:0] bw);
      return {nt, lg, bw};
   endfunction

   function automatic logic [CNT_W-1:0] hit_exp(input int h);
      return STATS ? CNT_W'(h) : '0;
   endfunction

   task automatic drive(input logic [N-1:0] bw, input logic lg, input logic [2*N-1:0] nt, input logic vld);
      in_or_bitwise = bw;
      in_or_logical = lg;
      in_not        = nt;
      in_valid      = vld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clr = 1'b0; out_ready = 1'b0;
      drive(3'b000, 1'b0, 6'b000000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 10'd0) begin errors++; $display("FAIL reset_out_data: got %b want 0", out_data); end
      checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_sticky); end
      checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL reset_hit: got %0d want 0", hit_cnt); end
      reset = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle: valid=%b ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive(3'b111, 1'b1, 6'b101010, 1'b1);
      step();
      exp_hit++;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic1_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== 10'b1010101111) begin errors++; $display("FAIL basic1_data: got %b want 1010101111", out_data); end
      checks++; if (hit_cnt !== hit_exp(exp_hit)) begin errors++; $display("FAIL basic1_hit: got %0d want %0d", hit_cnt, hit_exp(exp_hit)); end
      drive(3'b000, 1'b0, 6'b111111, 1'b1);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 10'b1111110000) begin errors++; $display("FAIL basic2_data: valid=%b data=%b want 1/1111110000", out_valid, out_data); end
      checks++; if (hit_cnt !== hit_exp(exp_hit)) begin errors++; $display("FAIL basic2_hit: got %0d want %0d", hit_cnt, hit_exp(exp_hit)); end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %b want 0", out_valid); end
      checks++; if (out_data !== 10'b1111110000) begin errors++; $display("FAIL empty_hold_data: got %b want 1111110000", out_data); end
   endtask

   task automatic test_full();
      logic [3*N:0] w1, w2, w3;
      w1 = word(6'b000111, 1'b1, 3'b001);
      w2 = word(6'b110000, 1'b1, 3'b100);
      w3 = word(6'b010101, 1'b0, 3'b000);
      out_ready = 1'b0;
      drive(3'b001, 1'b1, 6'b000111, 1'b1);
      step();
      checks++; if (out_data !== w1 || in_ready !== 1'b1) begin errors++; $display("FAIL full_w1: data=%b ready=%b want %b/1", out_data, in_ready, w1); end
      drive(3'b100, 1'b1, 6'b110000, 1'b1);
      step();
      exp_hit += 2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
      drive(3'b000, 1'b0, 6'b010101, 1'b1);
      step();
      checks++; if (in_ready !== 1'b0 || out_data !== w1) begin errors++; $display("FAIL full_stall: ready=%b data=%b want 0/%b", in_ready, out_data, w1); end
      out_ready = 1'b1;
      step();
      checks++; if (out_data !== w2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL full_pop1: data=%b ready=%b valid=%b want %b/1/1", out_data, in_ready, out_valid, w2); end
      step();
      checks++; if (out_data !== w3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_pop2: data=%b ready=%b want %b/1", out_data, in_ready, w3); end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: valid=%b want 0", out_valid); end
      checks++; if (hit_cnt !== hit_exp(exp_hit)) begin errors++; $display("FAIL full_hit: got %0d want %0d", hit_cnt, hit_exp(exp_hit)); end
   endtask

   task automatic test_err_clr();
      out_ready = 1'b1;
      drive(3'b000, 1'b1, 6'b111111, 1'b1);
      step();
      exp_hit++;
      checks++; if (err_sticky !== STATS) begin errors++; $display("FAIL err_set: got %b want %b", err_sticky, STATS); end
      checks++; if (hit_cnt !== hit_exp(exp_hit)) begin errors++; $display("FAIL err_hit: got %0d want %0d", hit_cnt, hit_exp(exp_hit)); end
      clr = 1'b1;
      step();
      exp_hit = 0;
      checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_err: got %b want 0", err_sticky); end
      checks++; if (hit_cnt !== 8'd0) begin errors++; $display("FAIL clr_hit: got %0d want 0", hit_cnt); end
      checks++; if (out_valid !== 1'b1 || out_data !== 10'b1111111000) begin errors++; $display("FAIL clr_fifo: valid=%b data=%b want 1/1111111000", out_valid, out_data); end
      clr = 1'b0;
      in_valid = 1'b0;
      step();
      checks++; if (err_sticky !== 1'b0 || hit_cnt !== 8'd0) begin errors++; $display("FAIL clr_hold: err=%b hit=%0d want 0/0", err_sticky, hit_cnt); end
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      drive(3'b010, 1'b1, 6'b101101, 1'b1);
      for (int i = 0; i < 254; i++) @(posedge clk);
      #1;
      checks++; if (hit_cnt !== hit_exp(254)) begin errors++; $display("FAIL sat_254: got %0d want %0d", hit_cnt, hit_exp(254)); end
      step();
      checks++; if (hit_cnt !== hit_exp(255)) begin errors++; $display("FAIL sat_255: got %0d want %0d", hit_cnt, hit_exp(255)); end
      step();
      step();
      exp_hit = 255;
      checks++; if (hit_cnt !== hit_exp(255)) begin errors++; $display("FAIL sat_stick: got %0d want %0d", hit_cnt, hit_exp(255)); end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(3'b011, 1'b1, 6'b100100, 1'b1);
      step();
      drive(3'b110, 1'b1, 6'b001001, 1'b1);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: valid=%b ready=%b want 1/0", out_valid, in_ready); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_flow: valid=%b ready=%b want 0/1", out_valid, in_ready); end
      checks++; if (hit_cnt !== 8'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL mid_reset_stats: hit=%0d err=%b want 0/0", hit_cnt, err_sticky); end
      checks++; if (out_data !== 10'd0) begin errors++; $display("FAIL mid_reset_data: got %b want 0", out_data); end
      exp_hit = 0;
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      drive(3'b100, 1'b1, 6'b011011, 1'b1);
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== word(6'b011011, 1'b1, 3'b100)) begin errors++; $display("FAIL after_reset_push: valid=%b data=%b want 1/%b", out_valid, out_data, word(6'b011011, 1'b1, 3'b100)); end
      checks++; if (hit_cnt !== hit_exp(1)) begin errors++; $display("FAIL after_reset_hit: got %0d want %0d", hit_cnt, hit_exp(1)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_err_clr();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
